// File: rtl/y_defs.sv
// rtl/y_defs.sv - shared state, opcode and ALU encodings for the y-series control unit
package y_defs;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_supported(input logic [6:0] opc);
    return opc inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};
  endfunction

endpackage

// File: rtl/y_ctrl_if.sv
// rtl/y_ctrl_if.sv - datapath-facing bundle between y_ctrl (master) and the yIF..yWB datapath (slave)
interface y_ctrl_if #(
  parameter int PC_W = 32
);
  logic [31:0]     ins;
  logic            zero;
  logic [PC_W-1:0] PCp4;
  logic [PC_W-1:0] branch;
  logic [PC_W-1:0] jTarget;
  logic [PC_W-1:0] PCin;
  logic            RegWrite;
  logic            ALUSrc;
  logic            Mem2Reg;
  logic            MemRead;
  logic            MemWrite;
  logic [2:0]      op;

  modport master (
    input  ins, zero, PCp4, branch, jTarget,
    output PCin, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op
  );

  modport slave (
    output ins, zero, PCp4, branch, jTarget,
    input  PCin, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op
  );
endinterface

// File: rtl/y_alu_dec.sv
// rtl/y_alu_dec.sv - combinational ALU operation decode from the latched instruction fields
module y_alu_dec
  import y_defs::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [2:0] op
);

  always_comb begin
    op = ALU_ADD;
    // loads and stores only ever need address arithmetic
    if (opcode != OP_LD && opcode != OP_ST) begin
      case (funct3)
        3'b000:  if (bit30 && opcode == OP_R) op = ALU_SUB;
        3'b111:  op = ALU_AND;
        3'b110:  op = ALU_OR;
        3'b010:  op = ALU_SLT;
        default: op = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/y_ctrl.sv
// rtl/y_ctrl.sv - multi-cycle control FSM and PC register; Y_CTRL_PERF_EN adds instret/cycles counters
module y_ctrl
  import y_defs::*;
#(
  parameter logic [31:0] PC_RESET = 32'h28,
  parameter int          PC_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  y_ctrl_if.master    dp,
`ifdef Y_CTRL_PERF_EN
  output logic [31:0] instret,
  output logic [31:0] cycles,
`endif
  output logic        retire,
  output logic        illegal
);

  state_t          state;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc;
  logic            reg_write, alu_src, mem2reg, mem_read, mem_write;
  logic            retire_q, illegal_q;
  logic [2:0]      op_q, dec_op;
  logic [6:0]      opcode;
  logic            unused_ir_bits;

  assign opcode         = ir[6:0];
  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

  y_alu_dec u_alu_dec (
    .opcode (opcode),
    .funct3 (ir[14:12]),
    .bit30  (ir[30]),
    .op     (dec_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      ir        <= '0;
      pc        <= PC_W'(PC_RESET);
      reg_write <= 1'b0;
      alu_src   <= 1'b0;
      mem2reg   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      op_q      <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // outputs are registered for the state being entered; pulses clear by default
      reg_write <= 1'b0;
      mem2reg   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      retire_q  <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (run) begin
            ir    <= dp.ins;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_supported(opcode)) begin
            state    <= ST_EXEC;
            alu_src  <= !(opcode == OP_R || opcode == OP_BR);
            op_q     <= (opcode == OP_BR) ? ALU_SUB : dec_op;
            retire_q <= (opcode == OP_BR || opcode == OP_JAL);
          end else begin
            illegal_q <= 1'b1;
            state     <= ST_HALT;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_R, OP_I: begin
              state     <= ST_WB;
              reg_write <= 1'b1;
              retire_q  <= 1'b1;
            end
            OP_LD: begin
              state    <= ST_MEM;
              mem_read <= 1'b1;
            end
            OP_ST: begin
              state     <= ST_MEM;
              mem_write <= 1'b1;
              retire_q  <= 1'b1;
            end
            OP_BR: begin
              state   <= ST_FETCH;
              pc      <= dp.zero ? dp.branch : dp.PCp4;
              alu_src <= 1'b0;
              op_q    <= '0;
            end
            default: begin
              state   <= ST_FETCH;
              pc      <= dp.jTarget;
              alu_src <= 1'b0;
              op_q    <= '0;
            end
          endcase
        end
        ST_MEM: begin
          if (opcode == OP_LD) begin
            state     <= ST_WB;
            reg_write <= 1'b1;
            mem2reg   <= 1'b1;
            mem_read  <= 1'b1;
            retire_q  <= 1'b1;
          end else begin
            state   <= ST_FETCH;
            pc      <= dp.PCp4;
            alu_src <= 1'b0;
            op_q    <= '0;
          end
        end
        ST_WB: begin
          state   <= ST_FETCH;
          pc      <= dp.PCp4;
          alu_src <= 1'b0;
          op_q    <= '0;
        end
        ST_HALT: begin
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  assign dp.PCin     = pc;
  assign dp.RegWrite = reg_write;
  assign dp.ALUSrc   = alu_src;
  assign dp.Mem2Reg  = mem2reg;
  assign dp.MemRead  = mem_read;
  assign dp.MemWrite = mem_write;
  assign dp.op       = op_q;
  assign retire      = retire_q;
  assign illegal     = illegal_q;

`ifdef Y_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
      cycles  <= '0;
    end else begin
      if (state != ST_HALT) cycles <= cycles + 32'd1;
      if (retire_q) instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_y_ctrl.sv
// tb/tb_y_ctrl.sv - scoreboard bench for y_ctrl: per-cycle expected outputs queued at issue, popped each cycle
module tb_y_ctrl;
  import y_defs::*;

  logic clk = 1'b0;
  logic rst, run, retire, illegal;
`ifdef Y_CTRL_PERF_EN
  logic [31:0] instret, cycles;
`endif

  y_ctrl_if #(.PC_W(32)) dp ();

  y_ctrl #(.PC_RESET(32'h28), .PC_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .dp      (dp),
`ifdef Y_CTRL_PERF_EN
    .instret (instret),
    .cycles  (cycles),
`endif
    .retire  (retire),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // yIF model: PCp4 follows PCin
  assign dp.PCp4 = dp.PCin + 32'd4;

  int checks = 0;
  int fails  = 0;
  int ret_m  = 0;
  logic [31:0] pc_m;

  typedef struct {
    logic [8:0]  val;
    logic [8:0]  mask;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  // vector = {RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, op[2:0], retire}
  localparam logic [8:0] M_FULL = 9'h1FF;
  localparam logic [8:0] M_IDLE = 9'h171;
  localparam logic [8:0] M_MEM  = 9'h171;
  localparam logic [8:0] M_HALT = 9'h1F1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] obs();
    return {dp.RegWrite, dp.ALUSrc, dp.Mem2Reg, dp.MemRead, dp.MemWrite, dp.op, retire};
  endfunction

  function automatic logic [8:0] vec(input logic rw, input logic as, input logic m2r,
                                     input logic mr, input logic mw, input logic [2:0] o,
                                     input logic ret);
    return {rw, as, m2r, mr, mw, o, ret};
  endfunction

  function automatic logic [2:0] alu_model(input logic [31:0] i);
    logic [6:0] opc;
    opc = i[6:0];
    if (opc == 7'h03 || opc == 7'h23) return 3'b010;
    case (i[14:12])
      3'b000:  return (opc == 7'h33 && i[30]) ? 3'b110 : 3'b010;
      3'b111:  return 3'b000;
      3'b110:  return 3'b001;
      3'b010:  return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  task automatic push_exp(input logic [8:0] v, input logic [8:0] m);
    exp_t e;
    e.val  = v;
    e.mask = m;
    e.pc   = pc_m;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exec_instr(input string name, input logic [31:0] i, input logic z,
                            input logic [31:0] br, input logic [31:0] jt);
    logic [6:0]  opc;
    logic [2:0]  a;
    logic [31:0] nxt;
    exp_t        e;
    int          n;
    opc = i[6:0];
    a   = alu_model(i);
    nxt = pc_m;
    push_exp(9'h0, M_IDLE);
    push_exp(9'h0, M_IDLE);
    case (opc)
      7'h33, 7'h13: begin
        push_exp(vec(1'b0, opc == 7'h13, 1'b0, 1'b0, 1'b0, a, 1'b0), M_FULL);
        push_exp(vec(1'b1, opc == 7'h13, 1'b0, 1'b0, 1'b0, a, 1'b1), M_FULL);
        nxt = pc_m + 32'd4;
      end
      7'h03: begin
        push_exp(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0), M_FULL);
        push_exp(vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0), M_MEM);
        push_exp(vec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1), M_FULL);
        nxt = pc_m + 32'd4;
      end
      7'h23: begin
        push_exp(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0), M_FULL);
        push_exp(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1), M_MEM);
        nxt = pc_m + 32'd4;
      end
      7'h63: begin
        push_exp(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 1'b1), M_FULL);
        nxt = z ? br : pc_m + 32'd4;
      end
      7'h6F: begin
        push_exp(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 1'b1), M_FULL);
        nxt = jt;
      end
      default: nxt = pc_m;
    endcase
    dp.ins     = i;
    dp.zero    = z;
    dp.branch  = br;
    dp.jTarget = jt;
    run        = 1'b1;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", name, k + 1), 32'(obs() & e.mask), 32'(e.val));
      check($sformatf("%s_pc%0d", name, k + 1), dp.PCin, e.pc);
      if (e.val[0]) ret_m++;
      cycle();
      run = 1'b0;
    end
    check($sformatf("%s_next_pc", name), dp.PCin, nxt);
    pc_m = nxt;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    run        = 1'b0;
    dp.ins     = '0;
    dp.zero    = 1'b0;
    dp.branch  = '0;
    dp.jTarget = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", dp.PCin, 32'h28);
    check("rst_vec", 32'(obs()), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_state", 32'(dut.state), 32'h0);
    rst  = 1'b0;
    pc_m = 32'h28;

    exec_instr("add", 32'h002081B3, 1'b0, 32'h0, 32'h0);
    check("add_pc_2c", dp.PCin, 32'h2C);
    exec_instr("sub",  32'h402081B3, 1'b0, 32'h0, 32'h0);
    exec_instr("and",  32'h0020F1B3, 1'b0, 32'h0, 32'h0);
    exec_instr("or",   32'h0020E1B3, 1'b0, 32'h0, 32'h0);
    exec_instr("slt",  32'h0020A1B3, 1'b0, 32'h0, 32'h0);
    exec_instr("addi", 32'h40008093, 1'b0, 32'h0, 32'h0);
    exec_instr("ori",  32'h0010E093, 1'b0, 32'h0, 32'h0);
    exec_instr("lw",   32'h0000A183, 1'b0, 32'h0, 32'h0);
    exec_instr("sw",   32'h0020A023, 1'b0, 32'h0, 32'h0);
    exec_instr("beq_t", 32'h00208063, 1'b1, 32'h40, 32'h0);
    check("beq_t_pc_40", dp.PCin, 32'h40);
    exec_instr("beq_nt", 32'h00208063, 1'b0, 32'h40, 32'h0);
    check("beq_nt_pc_44", dp.PCin, 32'h44);
    exec_instr("jal", 32'h000000EF, 1'b0, 32'h0, 32'h100);
    check("jal_pc_100", dp.PCin, 32'h100);

    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("idle_vec%0d", k), 32'(obs() & M_IDLE), 32'h0);
      check($sformatf("idle_pc%0d", k), dp.PCin, pc_m);
    end

    dp.ins = 32'hFFFFFFFF;
    run    = 1'b1;
    check("ill_fetch", 32'(obs() & M_IDLE), 32'h0);
    cycle();
    check("ill_decode_flag", 32'(illegal), 32'h0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check($sformatf("halt_illegal%0d", k), 32'(illegal), 32'h1);
      check($sformatf("halt_vec%0d", k), 32'(obs() & M_HALT), 32'h0);
      check($sformatf("halt_pc%0d", k), dp.PCin, pc_m);
    end
    run = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("halt_rst_pc", dp.PCin, 32'h28);
    check("halt_rst_illegal", 32'(illegal), 32'h0);
    check("halt_rst_vec", 32'(obs() & M_HALT), 32'h0);
    pc_m  = 32'h28;
    ret_m = 0;

    exec_instr("add2", 32'h002081B3, 1'b0, 32'h0, 32'h0);

    dp.ins = 32'h0020A023;
    run    = 1'b1;
    cycle();
    run = 1'b0;
    cycle();
    check("st_exec_vec", 32'(obs()), 32'(vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0)));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("st_rst_memwrite", 32'(dp.MemWrite), 32'h0);
    check("st_rst_pc", dp.PCin, 32'h28);
    check("st_rst_state", 32'(dut.state), 32'h0);
    cycle();
    check("st_rst_memwrite2", 32'(dp.MemWrite), 32'h0);
    check("st_rst_pc2", dp.PCin, 32'h28);
    pc_m  = 32'h28;
    ret_m = 0;

    exec_instr("add3", 32'h002081B3, 1'b0, 32'h0, 32'h0);
`ifdef Y_CTRL_PERF_EN
    check("perf_instret", instret, 32'(ret_m));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
